// File: rtl/fetch_unit_pkg.sv
// Shared core definitions for the instruction-fetch front end.
// Widths, reset defaults and fixed instruction constants.
package fetch_unit_pkg;

  localparam int INSTR_W = 32;
  localparam int DEF_XLEN = 32;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam int PC_STEP = 4;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO holding {pc, instruction} entries.
// Flush empties it in one cycle; async active-high reset.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  logic [WIDTH-1:0]             wdata,
  output logic [WIDTH-1:0]             rdata,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign rd_en = pop && (count != '0);
  assign wr_en = push && (rd_en || count != FULL);
  assign rdata = mem[rd_ptr];

  // Pointer, occupancy and storage update; flush drops all entries
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(wr_en) - CW'(rd_en);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Decoupled instruction-fetch stage: credit-based request issue,
// in-order responses into a prefetch buffer, redirect with discard.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int XLEN = DEF_XLEN,
  parameter int DEPTH = 4,
  parameter int MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEF_RESET_PC)
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_redirect_valid,
  input  logic [XLEN-1:0]    i_redirect_pc,
  output logic               o_imem_req_valid,
  input  logic               i_imem_req_ready,
  output logic [XLEN-1:0]    o_imem_req_addr,
  input  logic               i_imem_rsp_valid,
  input  logic [INSTR_W-1:0] i_imem_rsp_data,
  output logic               o_if_valid,
  input  logic               i_id_ready,
  output logic [INSTR_W-1:0] o_if_instruction,
  output logic [XLEN-1:0]    o_if_pc
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int EW = XLEN + INSTR_W;
  localparam logic [CW-1:0]   MAX_OUT = CW'(MAX_OUTSTANDING);
  localparam logic [CW:0]     CAP = (CW+1)'(DEPTH);
  localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] rsp_pc;
  logic [XLEN-1:0] target;
  logic [CW-1:0]   count;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   discard_cnt;
  logic [EW-1:0]   head;
  logic            credit;
  logic            req_fire;
  logic            rsp_take;
  logic            push;
  logic            pop;
  logic            unused_lo;

  assign unused_lo = &{1'b0, i_redirect_pc[1:0]};
  assign target = {i_redirect_pc[XLEN-1:2], 2'b00};

  // Buffer space is reserved at issue, so count+outstanding bounds depth
  assign credit = (outstanding < MAX_OUT) &&
                  (({1'b0, count} + {1'b0, outstanding}) < CAP);

  assign o_imem_req_valid = !i_reset && !i_redirect_valid && credit;
  assign o_imem_req_addr  = fetch_pc;
  assign req_fire = o_imem_req_valid && i_imem_req_ready;

  // Responses with nothing in flight are stale and ignored entirely
  assign rsp_take = i_imem_rsp_valid && (outstanding != '0);
  assign push = rsp_take && !i_redirect_valid && (discard_cnt == '0);

  assign o_if_valid = (count != '0) && !i_redirect_valid;
  assign pop = o_if_valid && i_id_ready;
  assign o_if_pc          = head[EW-1:INSTR_W];
  assign o_if_instruction = head[INSTR_W-1:0];

  // Request and response PC registers; redirect realigns both
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
    end else if (i_redirect_valid) begin
      fetch_pc <= target;
      rsp_pc   <= target;
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + STEP;
      if (push) rsp_pc <= rsp_pc + STEP;
    end
  end

  // In-flight tracking and count of stale responses to drop
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      outstanding <= '0;
      discard_cnt <= '0;
    end else begin
      outstanding <= outstanding + CW'(req_fire) - CW'(rsp_take);
      if (i_redirect_valid)
        discard_cnt <= outstanding - CW'(rsp_take);
      else if (rsp_take && discard_cnt != '0)
        discard_cnt <= discard_cnt - 1'b1;
    end
  end

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (i_clk),
    .rst   (i_reset),
    .push  (push),
    .pop   (pop),
    .flush (i_redirect_valid),
    .wdata ({rsp_pc, i_imem_rsp_data}),
    .rdata (head),
    .count (count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a latency-configurable
// in-order memory model and a PC/instruction scoreboard.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        if_valid;
  logic        id_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  int checks = 0;
  int fails = 0;
  int cyc = 0;
  int lat = 1;
  int pops = 0;
  int fires = 0;
  int p0;
  int f0;

  logic        id_rdy;
  logic        redir;
  logic [31:0] redir_pc;
  logic [31:0] exp_pc;
  logic [31:0] exp_req;
  logic [31:0] q_addr[$];
  int          q_due[$];
  logic        s_ifv;
  logic        s_reqv;
  logic        s_fire;

  always #5 clk = ~clk;

  fetch_unit #(
    .XLEN            (32),
    .DEPTH           (4),
    .MAX_OUTSTANDING (2),
    .RESET_PC        (32'h0)
  ) dut (
    .i_clk            (clk),
    .i_reset          (rst),
    .i_redirect_valid (redirect_valid),
    .i_redirect_pc    (redirect_pc),
    .o_imem_req_valid (req_valid),
    .i_imem_req_ready (req_ready),
    .o_imem_req_addr  (req_addr),
    .i_imem_rsp_valid (rsp_valid),
    .i_imem_rsp_data  (rsp_data),
    .o_if_valid       (if_valid),
    .i_id_ready       (id_ready),
    .o_if_instruction (if_instr),
    .o_if_pc          (if_pc)
  );

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    req_ready      = 1'b0;
    rsp_valid      = 1'b0;
    rsp_data       = '0;
    id_ready       = 1'b0;
  endtask

  task automatic do_reset(input bit keep_q);
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    #1;
    check("rst_reqv", {63'd0, req_valid}, 64'd0);
    check("rst_ifv", {63'd0, if_valid}, 64'd0);
    check("rst_addr", {32'd0, req_addr}, 64'd0);
    check("rst_pc", {32'd0, if_pc}, 64'd0);
    check("rst_instr", {32'd0, if_instr}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    if (!keep_q) begin
      q_addr.delete();
      q_due.delete();
    end
    exp_pc  = 32'h0;
    exp_req = 32'h0;
  endtask

  task automatic step();
    logic rsp_now;
    logic popd;
    @(negedge clk);
    rsp_now = (q_addr.size() > 0) && (q_due[0] <= cyc);
    rsp_valid      = rsp_now;
    rsp_data       = rsp_now ? word(q_addr[0]) : 32'h0;
    req_ready      = 1'b1;
    id_ready       = id_rdy;
    redirect_valid = redir;
    redirect_pc    = redir_pc;
    #1;
    s_ifv  = if_valid;
    s_reqv = req_valid;
    s_fire = req_valid && req_ready;
    popd   = if_valid && id_ready;
    if (redir) begin
      check("redir_ifv", {63'd0, if_valid}, 64'd0);
      check("redir_reqv", {63'd0, req_valid}, 64'd0);
    end
    if (s_fire) begin
      check("req_addr", {32'd0, req_addr}, {32'd0, exp_req});
      exp_req = exp_req + 32'd4;
    end
    if (popd) begin
      check("if_pc", {32'd0, if_pc}, {32'd0, exp_pc});
      check("if_instr", {32'd0, if_instr}, {32'd0, word(exp_pc)});
      exp_pc = exp_pc + 32'd4;
      pops++;
    end
    if (redir) begin
      exp_pc  = {redir_pc[31:2], 2'b00};
      exp_req = {redir_pc[31:2], 2'b00};
    end
    @(posedge clk);
    if (rsp_now) begin
      void'(q_addr.pop_front());
      void'(q_due.pop_front());
    end
    if (s_fire) begin
      q_addr.push_back(req_addr);
      q_due.push_back(cyc + lat);
      fires++;
      check("max_out", {63'd0, q_addr.size() <= 2}, 64'd1);
    end
    cyc++;
    redir = 1'b0;
  endtask

  initial begin
    id_rdy   = 1'b1;
    redir    = 1'b0;
    redir_pc = '0;
    do_reset(1'b0);

    // Streaming, 1-cycle memory
    lat = 1;
    step();
    check("t1_first_req", {63'd0, s_fire}, 64'd1);
    step();
    check("t1_ifv_n1", {63'd0, s_ifv}, 64'd0);
    step();
    check("t1_ifv_n2", {63'd0, s_ifv}, 64'd1);
    p0 = pops;
    repeat (8) step();
    check("t1_rate", 64'(pops - p0), 64'd8);

    // Decode stalled: buffer fills to depth
    do_reset(1'b0);
    id_rdy = 1'b0;
    f0 = fires;
    repeat (10) step();
    check("t2_fires", 64'(fires - f0), 64'd4);
    check("t2_reqv_off", {63'd0, s_reqv}, 64'd0);
    id_rdy = 1'b1;
    p0 = pops;
    repeat (6) step();
    check("t2_drain", {63'd0, (pops - p0) >= 4}, 64'd1);

    // 3-cycle memory latency
    do_reset(1'b0);
    lat = 3;
    p0 = pops;
    repeat (30) step();
    check("t3_pops", {63'd0, (pops - p0) >= 10}, 64'd1);

    // Redirect with two requests in flight and entries buffered
    do_reset(1'b0);
    lat = 3;
    id_rdy = 1'b0;
    repeat (6) step();
    check("t4_inflight", 64'(q_addr.size()), 64'd2);
    redir = 1'b1;
    redir_pc = 32'h0000_0104;
    step();
    id_rdy = 1'b1;
    p0 = pops;
    repeat (12) step();
    check("t4_resume", {63'd0, (pops - p0) >= 2}, 64'd1);

    // Redirect coinciding with a response and a pop request
    do_reset(1'b0);
    lat = 1;
    id_rdy = 1'b1;
    repeat (5) step();
    check("t5_rsp_due", {63'd0, (q_addr.size() == 1) && (q_due[0] <= cyc)}, 64'd1);
    p0 = pops;
    redir = 1'b1;
    redir_pc = 32'h0000_0203;
    step();
    check("t5_no_pop", 64'(pops - p0), 64'd0);
    repeat (6) step();
    check("t5_resume", {63'd0, (pops - p0) >= 3}, 64'd1);

    // Asynchronous reset between clock edges, stale response after
    repeat (2) step();
    #3;
    rst = 1'b1;
    #1;
    check("t6_reqv", {63'd0, req_valid}, 64'd0);
    check("t6_ifv", {63'd0, if_valid}, 64'd0);
    check("t6_addr", {32'd0, req_addr}, 64'd0);
    check("t6_pc", {32'd0, if_pc}, 64'd0);
    do_reset(1'b1);
    check("t6_stale", {63'd0, q_addr.size() > 0}, 64'd1);
    p0 = pops;
    step();
    check("t6_first_req", {63'd0, s_fire}, 64'd1);
    repeat (4) step();
    check("t6_resume", {63'd0, (pops - p0) >= 2}, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
